// File: rtl/add_approx_pkg.sv
// Shared types and helpers for the lower-part-OR approximate adder pipeline.
package add_approx_pkg;

  typedef enum logic {
    MODE_APPROX = 1'b0,
    MODE_EXACT  = 1'b1
  } mode_e;

  function automatic int unsigned approx_err_w(input int unsigned k);
    return k + 1;
  endfunction

  // Saturates at 2^width - 1; caller truncates the result back to its own width.
  function automatic logic [63:0] sat_inc(input logic [63:0] value, input int unsigned width);
    logic [63:0] limit;
    limit = ~({64{1'b1}} << width);
    return (value >= limit) ? value : value + 64'd1;
  endfunction

endpackage

// File: rtl/add_approx_pipe_if.sv
// Operand/result stream bundle for add_approx_pipe (valid/ready both directions).
interface add_approx_pipe_if #(
  parameter int unsigned W = 8,
  parameter int unsigned K = 4
) ();
  import add_approx_pkg::*;

  localparam int unsigned EW = approx_err_w(K);

  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  A;
  logic [W-1:0]  B;
  logic          mode;
  logic          out_valid;
  logic          out_ready;
  logic [W:0]    O;
  logic [EW-1:0] out_err;

  modport master (
    output in_valid, A, B, mode, out_ready,
    input  in_ready, out_valid, O, out_err
  );

  modport slave (
    input  in_valid, A, B, mode, out_ready,
    output in_ready, out_valid, O, out_err
  );

endinterface

// File: rtl/add_approx_core.sv
// Combinational approximate/exact adder, split into a low-part half (fed by raw
// operands) and an upper-part half (fed by the stage-1 registers).
module add_approx_core
  import add_approx_pkg::*;
#(
  parameter int unsigned W = 8,
  parameter int unsigned K = 4
) (
  input  logic [W-1:0]               a,
  input  logic [W-1:0]               b,
  output logic [W-1:0]               lo_approx,
  output logic [W-1:0]               lo_exact,
  output logic [W-1:0]               a_hi,
  output logic [W-1:0]               b_hi,
  output logic                       c_approx,
  output logic                       c_exact,
  input  logic [W-1:0]               s1_lo_approx,
  input  logic [W-1:0]               s1_lo_exact,
  input  logic [W-1:0]               s1_a_hi,
  input  logic [W-1:0]               s1_b_hi,
  input  logic                       s1_c_approx,
  input  logic                       s1_c_exact,
  input  mode_e                      mode,
  output logic [W:0]                 sum_approx,
  output logic [W:0]                 sum_exact,
  output logic [approx_err_w(K)-1:0] err
);

  localparam int unsigned EW = approx_err_w(K);
  // Operands stay in place with masks, so K=0 and K=W need no zero-width slices.
  localparam logic [W-1:0] LO_MASK   = ~({W{1'b1}} << K);
  localparam logic [W-1:0] TOP_BIT   = (K == 0) ? '0 : (W'(1) << (K - 1));
  localparam logic [W:0]   CARRY_BIT = (W + 1)'(1) << K;

  logic [W:0] lo_sum;
  logic [W:0] cin_approx;
  logic [W:0] cin_exact;
  logic [W:0] diff;

  always_comb begin
    lo_approx = (a | b) & LO_MASK;
    lo_sum    = {1'b0, a & LO_MASK} + {1'b0, b & LO_MASK};
    lo_exact  = W'(lo_sum) & LO_MASK;
    c_exact   = |(lo_sum & CARRY_BIT);
    c_approx  = |(a & b & TOP_BIT);
    a_hi      = a & ~LO_MASK;
    b_hi      = b & ~LO_MASK;
  end

  always_comb begin
    cin_approx = {{W{1'b0}}, s1_c_approx} << K;
    cin_exact  = {{W{1'b0}}, s1_c_exact} << K;
    sum_approx = ({1'b0, s1_a_hi} + {1'b0, s1_b_hi} + cin_approx) | {1'b0, s1_lo_approx};
    sum_exact  = ({1'b0, s1_a_hi} + {1'b0, s1_b_hi} + cin_exact) | {1'b0, s1_lo_exact};
    diff       = (sum_approx >= sum_exact) ? (sum_approx - sum_exact) : (sum_exact - sum_approx);
    err        = (mode == MODE_EXACT) ? '0 : EW'(diff);
  end

endmodule

// File: rtl/add_approx_pipe.sv
// Two-stage pipelined approximate adder with valid/ready handshake and
// saturating error statistics over delivered beats.
module add_approx_pipe
  import add_approx_pkg::*;
#(
  parameter int unsigned W     = 8,
  parameter int unsigned K     = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  add_approx_pipe_if.slave           bus,
  input  logic                       stat_clr,
  output logic [CNT_W-1:0]           txn_cnt,
  output logic [CNT_W-1:0]           err_cnt,
  output logic [approx_err_w(K)-1:0] err_max
);

  localparam int unsigned EW = approx_err_w(K);

  generate
    if (K > W) begin : g_bad_k
      $error("add_approx_pipe: K (%0d) must not exceed W (%0d)", K, W);
    end
    if (CNT_W < 1 || CNT_W > 64) begin : g_bad_cnt
      $error("add_approx_pipe: CNT_W (%0d) must be 1..64", CNT_W);
    end
  endgenerate

  logic          in_ready;
  logic          accept;
  logic          s2_free;
  logic          deliver;

  logic [W-1:0]  lo_approx, lo_exact, a_hi, b_hi;
  logic          c_approx, c_exact;
  logic [W:0]    sum_approx, sum_exact;
  logic [EW-1:0] err;

  logic          s1_valid;
  logic [W-1:0]  s1_lo_approx, s1_lo_exact, s1_a_hi, s1_b_hi;
  logic          s1_c_approx, s1_c_exact;
  mode_e         s1_mode;

  logic          s2_valid;
  logic [W:0]    s2_approx, s2_exact;
  logic [EW-1:0] s2_err;
  mode_e         s2_mode;

  add_approx_core #(.W(W), .K(K)) u_core (
    .a            (bus.A),
    .b            (bus.B),
    .lo_approx    (lo_approx),
    .lo_exact     (lo_exact),
    .a_hi         (a_hi),
    .b_hi         (b_hi),
    .c_approx     (c_approx),
    .c_exact      (c_exact),
    .s1_lo_approx (s1_lo_approx),
    .s1_lo_exact  (s1_lo_exact),
    .s1_a_hi      (s1_a_hi),
    .s1_b_hi      (s1_b_hi),
    .s1_c_approx  (s1_c_approx),
    .s1_c_exact   (s1_c_exact),
    .mode         (s1_mode),
    .sum_approx   (sum_approx),
    .sum_exact    (sum_exact),
    .err          (err)
  );

  always_comb begin
    s2_free  = !s2_valid || bus.out_ready;
    in_ready = !s1_valid || s2_free;
    accept   = bus.in_valid && in_ready;
    deliver  = s2_valid && bus.out_ready;
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = s2_valid;
  assign bus.O         = (s2_mode == MODE_EXACT) ? s2_exact : s2_approx;
  assign bus.out_err   = s2_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid     <= 1'b0;
      s1_lo_approx <= '0;
      s1_lo_exact  <= '0;
      s1_a_hi      <= '0;
      s1_b_hi      <= '0;
      s1_c_approx  <= 1'b0;
      s1_c_exact   <= 1'b0;
      s1_mode      <= MODE_APPROX;
    end else begin
      if (in_ready) s1_valid <= bus.in_valid;
      if (accept) begin
        s1_lo_approx <= lo_approx;
        s1_lo_exact  <= lo_exact;
        s1_a_hi      <= a_hi;
        s1_b_hi      <= b_hi;
        s1_c_approx  <= c_approx;
        s1_c_exact   <= c_exact;
        s1_mode      <= mode_e'(bus.mode);
      end
    end
  end

  // O is a mux of registered sums, so it still holds steady while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid  <= 1'b0;
      s2_approx <= '0;
      s2_exact  <= '0;
      s2_err    <= '0;
      s2_mode   <= MODE_APPROX;
    end else if (s2_free) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_approx <= sum_approx;
        s2_exact  <= sum_exact;
        s2_err    <= err;
        s2_mode   <= s1_mode;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txn_cnt <= '0;
      err_cnt <= '0;
      err_max <= '0;
    end else if (stat_clr) begin
      txn_cnt <= '0;
      err_cnt <= '0;
      err_max <= '0;
    end else if (deliver) begin
      txn_cnt <= CNT_W'(sat_inc(64'(txn_cnt), CNT_W));
      if (s2_err != '0) err_cnt <= CNT_W'(sat_inc(64'(err_cnt), CNT_W));
      if (s2_err > err_max) err_max <= s2_err;
    end
  end

endmodule
